// File: rtl/int_bus_gateway.sv
// rtl/int_bus_gateway.sv - interrupt bus receiver: per-source gateways plus claim/complete ports
//
// Level interrupts arrive from the interrupt crossbar, pass a synchronizer and latch into a
// per-source gateway (idle / pending / in-flight). The lowest-numbered pending, enabled source
// is offered on the claim port. The consumer returns the ID on the complete port to re-arm
// that gateway.
//
// Ports:
//   clock          single clock
//   reset          synchronous, active-low
//   int_in         level interrupts, bit i = source ID i+1 (may be asynchronous)
//   int_en         per-source enable, sampled every cycle
//   claim_valid    an ID is offered on claim_id
//   claim_id       offered source ID, 0 when nothing is offered
//   claim_ready    consumer accepts the offered ID this cycle
//   complete_valid completion strobe
//   complete_id    ID being completed
//   irq            copy of claim_valid
module int_bus_gateway #(
  parameter int NUM_SRC     = 8,
  parameter int ID_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] int_in,
  input  logic [NUM_SRC-1:0] int_en,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               claim_ready,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic               irq
);

  localparam logic [1:0] GW_IDLE     = 2'd0;
  localparam logic [1:0] GW_PENDING  = 2'd1;
  localparam logic [1:0] GW_INFLIGHT = 2'd2;

  localparam logic [0:0] CL_EMPTY = 1'b0;
  localparam logic [0:0] CL_OFFER = 1'b1;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_s;

  logic [1:0]      gw_q [NUM_SRC];
  logic [1:0]      gw_d [NUM_SRC];
  logic [0:0]      cl_state_q, cl_state_d;
  logic [ID_W-1:0] claim_id_q, claim_id_d;
  logic [ID_W-1:0] pick_id;
  logic            accept;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= int_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign accept = (cl_state_q == CL_OFFER) && claim_ready;

  // Lowest ID wins: scan from the top so the last hit is the lowest pending, enabled source.
  always_comb begin
    pick_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (gw_q[i] == GW_PENDING && int_en[i]) pick_id = ID_W'(i + 1);
    end
  end

  // A level held high while in flight is ignored; it re-pends only from IDLE, one cycle after
  // completion. Completions of non-inflight or out-of-range IDs match no gateway.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      gw_d[i] = gw_q[i];
      case (gw_q[i])
        GW_IDLE:     if (sync_s[i]) gw_d[i] = GW_PENDING;
        GW_PENDING:  if (accept && claim_id_q == ID_W'(i + 1)) gw_d[i] = GW_INFLIGHT;
        GW_INFLIGHT: if (complete_valid && complete_id == ID_W'(i + 1)) gw_d[i] = GW_IDLE;
        default:     gw_d[i] = GW_IDLE;
      endcase
    end
  end

  // An offer is never retracted; acceptance forces one empty cycle before the next offer.
  always_comb begin
    cl_state_d = cl_state_q;
    claim_id_d = claim_id_q;
    case (cl_state_q)
      CL_EMPTY: begin
        claim_id_d = pick_id;
        if (pick_id != '0) cl_state_d = CL_OFFER;
      end
      default: begin
        if (claim_ready) begin
          claim_id_d = '0;
          cl_state_d = CL_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) gw_q[i] <= GW_IDLE;
      cl_state_q <= CL_EMPTY;
      claim_id_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) gw_q[i] <= gw_d[i];
      cl_state_q <= cl_state_d;
      claim_id_q <= claim_id_d;
    end
  end

  assign claim_valid = (cl_state_q == CL_OFFER);
  assign claim_id    = claim_id_q;
  assign irq         = claim_valid;

endmodule
